// File: rtl/hazard_ctrl_pipe_if.sv
// Bundle between the decoders/datapath and the hazard/pipeline-control unit.
// The decode-stage controls flow into the unit; stage controls, hazard and forwarding selects flow out.
interface hazard_ctrl_pipe_if #(
  parameter int unsigned CNT_W = 16
);
  logic             regwriteD, memtoregD, memwriteD, branchD, alusrcD, regdstD;
  logic [2:0]       alucontrolD;
  logic [4:0]       rsD, rtD, rdD;

  logic             stallF, stallD, flushE;
  logic             forwardAD, forwardBD;
  logic [1:0]       forwardAE, forwardBE;

  logic             regwriteE, memtoregE, memwriteE, alusrcE, regdstE;
  logic [2:0]       alucontrolE;
  logic [4:0]       rsE, rtE, rdE, writeregE;

  logic             regwriteM, memtoregM, memwriteM;
  logic [4:0]       writeregM;

  logic             regwriteW, memtoregW;
  logic [4:0]       writeregW;

  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output regwriteD, memtoregD, memwriteD, branchD, alusrcD, regdstD,
    output alucontrolD, rsD, rtD, rdD,
    input  stallF, stallD, flushE, forwardAD, forwardBD, forwardAE, forwardBE,
    input  regwriteE, memtoregE, memwriteE, alusrcE, regdstE, alucontrolE,
    input  rsE, rtE, rdE, writeregE,
    input  regwriteM, memtoregM, memwriteM, writeregM,
    input  regwriteW, memtoregW, writeregW,
    input  stall_cnt
  );

  modport slave (
    input  regwriteD, memtoregD, memwriteD, branchD, alusrcD, regdstD,
    input  alucontrolD, rsD, rtD, rdD,
    output stallF, stallD, flushE, forwardAD, forwardBD, forwardAE, forwardBE,
    output regwriteE, memtoregE, memwriteE, alusrcE, regdstE, alucontrolE,
    output rsE, rtE, rdE, writeregE,
    output regwriteM, memtoregM, memwriteM, writeregM,
    output regwriteW, memtoregW, writeregW,
    output stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl_pipe.sv
// ID/EX, EX/MEM and MEM/WB control registers with load-use / branch hazard detection,
// forwarding selects and a saturating stall-cycle counter.
module hazard_ctrl_pipe #(
  parameter int unsigned CNT_W = 16
) (
  input logic               clk,
  input logic               resetn,
  hazard_ctrl_pipe_if.slave bus
);

  logic             regwrite_e_q, memtoreg_e_q, memwrite_e_q, alusrc_e_q, regdst_e_q;
  logic [2:0]       alucontrol_e_q;
  logic [4:0]       rs_e_q, rt_e_q, rd_e_q;
  logic             regwrite_m_q, memtoreg_m_q, memwrite_m_q;
  logic [4:0]       writereg_m_q;
  logic             regwrite_w_q, memtoreg_w_q;
  logic [4:0]       writereg_w_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic       lw_stall, br_stall, stall;
  logic [4:0] writereg_e;
  logic [1:0] fwd_ae, fwd_be;

  // $0 is hard-wired, so a pipeline index of 0 never produces a dependency.
  function automatic logic reg_match(input logic [4:0] pipe_idx, input logic [4:0] src_idx);
    return (pipe_idx != 5'd0) && (pipe_idx == src_idx);
  endfunction

  assign writereg_e = regdst_e_q ? rd_e_q : rt_e_q;

  always_comb begin
    lw_stall = memtoreg_e_q &
               (reg_match(rt_e_q, bus.rsD) | reg_match(rt_e_q, bus.rtD));
    br_stall = bus.branchD &
               ((regwrite_e_q &
                 (reg_match(writereg_e, bus.rsD) | reg_match(writereg_e, bus.rtD))) |
                (memtoreg_m_q &
                 (reg_match(writereg_m_q, bus.rsD) | reg_match(writereg_m_q, bus.rtD))));
    stall    = lw_stall | br_stall;
  end

  // MEM result is younger than WB, so it wins when both match.
  always_comb begin
    fwd_ae = 2'b00;
    if (regwrite_m_q && reg_match(writereg_m_q, rs_e_q)) begin
      fwd_ae = 2'b10;
    end else if (regwrite_w_q && reg_match(writereg_w_q, rs_e_q)) begin
      fwd_ae = 2'b01;
    end
    fwd_be = 2'b00;
    if (regwrite_m_q && reg_match(writereg_m_q, rt_e_q)) begin
      fwd_be = 2'b10;
    end else if (regwrite_w_q && reg_match(writereg_w_q, rt_e_q)) begin
      fwd_be = 2'b01;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      regwrite_e_q   <= 1'b0;
      memtoreg_e_q   <= 1'b0;
      memwrite_e_q   <= 1'b0;
      alusrc_e_q     <= 1'b0;
      regdst_e_q     <= 1'b0;
      alucontrol_e_q <= 3'd0;
      rs_e_q         <= 5'd0;
      rt_e_q         <= 5'd0;
      rd_e_q         <= 5'd0;
      regwrite_m_q   <= 1'b0;
      memtoreg_m_q   <= 1'b0;
      memwrite_m_q   <= 1'b0;
      writereg_m_q   <= 5'd0;
      regwrite_w_q   <= 1'b0;
      memtoreg_w_q   <= 1'b0;
      writereg_w_q   <= 5'd0;
      stall_cnt_q    <= '0;
    end else begin
      // A stall never holds ID/EX; it becomes a bubble while F/D keep their contents.
      if (stall) begin
        regwrite_e_q   <= 1'b0;
        memtoreg_e_q   <= 1'b0;
        memwrite_e_q   <= 1'b0;
        alusrc_e_q     <= 1'b0;
        regdst_e_q     <= 1'b0;
        alucontrol_e_q <= 3'd0;
        rs_e_q         <= 5'd0;
        rt_e_q         <= 5'd0;
        rd_e_q         <= 5'd0;
      end else begin
        regwrite_e_q   <= bus.regwriteD;
        memtoreg_e_q   <= bus.memtoregD;
        memwrite_e_q   <= bus.memwriteD;
        alusrc_e_q     <= bus.alusrcD;
        regdst_e_q     <= bus.regdstD;
        alucontrol_e_q <= bus.alucontrolD;
        rs_e_q         <= bus.rsD;
        rt_e_q         <= bus.rtD;
        rd_e_q         <= bus.rdD;
      end
      regwrite_m_q <= regwrite_e_q;
      memtoreg_m_q <= memtoreg_e_q;
      memwrite_m_q <= memwrite_e_q;
      writereg_m_q <= writereg_e;
      regwrite_w_q <= regwrite_m_q;
      memtoreg_w_q <= memtoreg_m_q;
      writereg_w_q <= writereg_m_q;
      if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign bus.stallF      = stall;
  assign bus.stallD      = stall;
  assign bus.flushE      = stall;
  assign bus.forwardAD   = regwrite_m_q & reg_match(writereg_m_q, bus.rsD);
  assign bus.forwardBD   = regwrite_m_q & reg_match(writereg_m_q, bus.rtD);
  assign bus.forwardAE   = fwd_ae;
  assign bus.forwardBE   = fwd_be;
  assign bus.regwriteE   = regwrite_e_q;
  assign bus.memtoregE   = memtoreg_e_q;
  assign bus.memwriteE   = memwrite_e_q;
  assign bus.alusrcE     = alusrc_e_q;
  assign bus.regdstE     = regdst_e_q;
  assign bus.alucontrolE = alucontrol_e_q;
  assign bus.rsE         = rs_e_q;
  assign bus.rtE         = rt_e_q;
  assign bus.rdE         = rd_e_q;
  assign bus.writeregE   = writereg_e;
  assign bus.regwriteM   = regwrite_m_q;
  assign bus.memtoregM   = memtoreg_m_q;
  assign bus.memwriteM   = memwrite_m_q;
  assign bus.writeregM   = writereg_m_q;
  assign bus.regwriteW   = regwrite_w_q;
  assign bus.memtoregW   = memtoreg_w_q;
  assign bus.writeregW   = writereg_w_q;
  assign bus.stall_cnt   = stall_cnt_q;

endmodule
